// File: rtl/regs_pkg.sv
// Shared register-file definitions: data width, register count and address type.
// The register file and its write-port arbiter both import this package.
package regs_pkg;

  localparam int N    = 32;
  localparam int NREG = 4;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a one-hot grant. The pointer holds the index of the
// most recent grant, so the search for a winner starts one position past it.
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] valid,
  input  logic            accept_en,
  output logic [NREQ-1:0] grant
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [LW-1:0]   last_q;
  logic [LW-1:0]   last_d;
  logic [NREQ-1:0] grant_d;
  logic            found;
  int              idx;

  always_comb begin
    grant_d = '0;
    last_d  = last_q;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && valid[idx]) begin
        found        = 1'b1;
        grant_d[idx] = 1'b1;
        last_d       = LW'(idx);
      end
    end
  end

  assign grant = accept_en ? grant_d : '0;

  // Reset to the last index so requester 0 wins the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= LW'(NREQ - 1);
    end else if (accept_en && found) begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regwrite_arbiter.sv
// Shares the register-file write port between writeback requesters and keeps a
// per-register busy scoreboard that the issue stage uses to stall.
module regwrite_arbiter
  import regs_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*N-1:0]  req_mask,
  input  logic [NREQ*N-1:0]  req_data,
  output logic [AW-1:0]    w1,
  output logic [N-1:0]     mask,
  output logic             wf,
  output logic [N-1:0]     w,
  input  logic             rsv_valid,
  input  reg_addr_t        rsv_addr,
  input  reg_addr_t        r1,
  input  reg_addr_t        r2,
  output logic [NREG-1:0]  busy,
  output logic             stall
);

  logic [NREQ-1:0] grant;
  logic            accept;
  reg_addr_t       win_addr;
  logic [N-1:0]    win_mask;
  logic [N-1:0]    win_data;

  // No downstream backpressure: whatever the arbiter selects is accepted.
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (req_valid),
    .accept_en (1'b1),
    .grant     (grant)
  );

  assign accept    = |grant;
  assign req_ready = grant;

  always_comb begin
    win_addr = '0;
    win_mask = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_addr = req_addr[i*AW +: AW];
        win_mask = req_mask[i*N +: N];
        win_data = req_data[i*N +: N];
      end
    end
  end

  logic            wf_q, wf_d;
  reg_addr_t       w1_q;
  logic [N-1:0]    mask_q;
  logic [N-1:0]    w_q;

  // Writes to register 0 or with an empty mask are consumed but never issued.
  assign wf_d = accept && (win_addr != REG_ZERO) && (|win_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wf_q   <= 1'b0;
      w1_q   <= '0;
      mask_q <= '0;
      w_q    <= '0;
    end else begin
      wf_q <= wf_d;
      if (accept) begin
        w1_q   <= win_addr;
        mask_q <= win_mask;
        w_q    <= win_data;
      end
    end
  end

  assign wf   = wf_q;
  assign w1   = w1_q;
  assign mask = mask_q;
  assign w    = w_q;

  logic [NREG-1:0] busy_q, busy_d;

  // Set is applied after clear so a same-address reservation keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (accept) busy_d[win_addr] = 1'b0;
    if (rsv_valid && (rsv_addr != REG_ZERO)) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy  = busy_q;
  assign stall = busy_q[r1] | busy_q[r2];

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter: stimulus queues expected grants and
// writes, a negedge monitor pops and compares them as the DUT presents them.
module tb_regwrite_arbiter;
  import regs_pkg::*;

  localparam int NREQ = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*N-1:0]   req_mask;
  logic [NREQ*N-1:0]   req_data;
  logic [AW-1:0]       w1;
  logic [N-1:0]        mask;
  logic                wf;
  logic [N-1:0]        w;
  logic                rsv_valid;
  reg_addr_t           rsv_addr;
  reg_addr_t           r1, r2;
  logic [NREG-1:0]     busy;
  logic                stall;

  regwrite_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_mask(req_mask), .req_data(req_data),
    .w1(w1), .mask(mask), .wf(wf), .w(w),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .r1(r1), .r2(r2), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [N-1:0]  mask;
    logic [N-1:0]  data;
  } wr_t;

  logic [NREQ-1:0] exp_grant_q[$];
  wr_t             exp_wr_q[$];
  logic [N-1:0]    regf [NREG];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference register file: merges issued writes under their mask.
  initial for (int i = 0; i < NREG; i++) regf[i] = '0;
  always @(posedge clk)
    if (rst_n && wf && (w1 != REG_ZERO))
      regf[w1] <= (regf[w1] & ~mask) | (w & mask);

  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ready != '0) begin
        if (exp_grant_q.size() == 0) check("unexpected_grant", 32'(req_ready), 32'd0);
        else check("grant", 32'(req_ready), 32'(exp_grant_q.pop_front()));
      end
      if (wf) begin
        if (exp_wr_q.size() == 0) check("unexpected_wf", 32'(wf), 32'd0);
        else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          check("w1", 32'(w1), 32'(e.addr));
          check("mask", mask, e.mask);
          check("w", w, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [N-1:0] m,
                         input logic [N-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_mask[i*N +: N]   = m;
    req_data[i*N +: N]   = d;
  endtask

  task automatic push_grant(input int i);
    logic [NREQ-1:0] g;
    g = '0;
    g[i] = 1'b1;
    exp_grant_q.push_back(g);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [N-1:0] m, input logic [N-1:0] d);
    wr_t e;
    e.addr = a; e.mask = m; e.data = d;
    exp_wr_q.push_back(e);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int rr_seq [10] = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2};

  initial begin
    rst_n = 1'b1;
    req_valid = '0; req_addr = '0; req_mask = '0; req_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0; r1 = '0; r2 = '0;
    #2 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_wf", 32'(wf), 32'd0);
    check("rst_w1", 32'(w1), 32'd0);
    check("rst_mask", mask, 32'd0);
    check("rst_w", w, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);

    // Round-robin: all three, then requester 1 drops out.
    set_req(0, 2'd1, 32'hFFFF_FFFF, 32'h1111_1111);
    set_req(1, 2'd2, 32'hFFFF_FFFF, 32'h2222_2222);
    set_req(2, 2'd3, 32'hFFFF_FFFF, 32'h3333_3333);
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 6) ? 3'b111 : 3'b101;
      push_grant(rr_seq[c]);
      case (rr_seq[c])
        0: push_wr(2'd1, 32'hFFFF_FFFF, 32'h1111_1111);
        1: push_wr(2'd2, 32'hFFFF_FFFF, 32'h2222_2222);
        default: push_wr(2'd3, 32'hFFFF_FFFF, 32'h3333_3333);
      endcase
      tick();
    end
    req_valid = '0;
    tick();
    check("rr_reg2", regf[2], 32'h2222_2222);

    // Single requester.
    set_req(1, 2'd1, 32'hFFFF_FFFF, 32'hCAFE_BABE);
    req_valid = 3'b010;
    push_grant(1);
    push_wr(2'd1, 32'hFFFF_FFFF, 32'hCAFE_BABE);
    tick();
    req_valid = '0;
    tick();
    check("single_reg1", regf[1], 32'hCAFE_BABE);

    // Write to register 0 is consumed but suppressed.
    set_req(0, 2'd0, 32'hFFFF_FFFF, 32'hBABE_C0FF);
    req_valid = 3'b001;
    push_grant(0);
    tick();
    req_valid = '0;
    check("addr0_wf", 32'(wf), 32'd0);
    tick();
    check("addr0_reg0", regf[0], 32'd0);

    // Empty mask: no write, but the busy bit still clears.
    rsv_valid = 1'b1; rsv_addr = 2'd2;
    tick();
    rsv_valid = 1'b0;
    check("rsv2_busy", 32'(busy), 32'h4);
    set_req(2, 2'd2, 32'h0000_0000, 32'h1234_5678);
    req_valid = 3'b100;
    push_grant(2);
    tick();
    req_valid = '0;
    check("mask0_wf", 32'(wf), 32'd0);
    check("mask0_busy", 32'(busy), 32'h0);

    // Scoreboard set, stall decode, simultaneous set/clear.
    rsv_valid = 1'b1; rsv_addr = 2'd3;
    tick();
    rsv_valid = 1'b0;
    check("rsv3_busy", 32'(busy), 32'h8);
    r1 = 2'd0; r2 = 2'd3; #1;
    check("stall_r2_3", 32'(stall), 32'd1);
    r1 = 2'd1; r2 = 2'd2; #1;
    check("stall_r12", 32'(stall), 32'd0);

    set_req(1, 2'd3, 32'hFFFF_FFFF, 32'h3333_4444);
    req_valid = 3'b010;
    rsv_valid = 1'b1; rsv_addr = 2'd3;
    push_grant(1);
    push_wr(2'd3, 32'hFFFF_FFFF, 32'h3333_4444);
    tick();
    req_valid = '0; rsv_valid = 1'b0;
    check("same_addr_busy", 32'(busy), 32'h8);
    r1 = 2'd3; r2 = 2'd3; #1;
    check("same_addr_stall", 32'(stall), 32'd1);

    set_req(0, 2'd3, 32'hFFFF_FFFF, 32'h4444_4444);
    req_valid = 3'b001;
    rsv_valid = 1'b1; rsv_addr = 2'd1;
    push_grant(0);
    push_wr(2'd3, 32'hFFFF_FFFF, 32'h4444_4444);
    tick();
    req_valid = '0; rsv_valid = 1'b0;
    check("diff_addr_busy", 32'(busy), 32'h2);
    check("clear3_stall", 32'(stall), 32'd0);
    r2 = 2'd1; #1;
    check("stall_r2_1", 32'(stall), 32'd1);

    // Masked merge into register 2.
    set_req(0, 2'd2, 32'h0000_FFFF, 32'hC0FF_EEFF);
    req_valid = 3'b001;
    push_grant(0);
    push_wr(2'd2, 32'h0000_FFFF, 32'hC0FF_EEFF);
    tick();
    set_req(0, 2'd2, 32'hFFFF_0000, 32'hC0FF_EEFF);
    push_grant(0);
    push_wr(2'd2, 32'hFFFF_0000, 32'hC0FF_EEFF);
    tick();
    req_valid = '0;
    tick();
    check("merge_reg2", regf[2], 32'hC0FF_EEFF);
    check("merge_reg3", regf[3], 32'h4444_4444);

    // Reset mid-operation drops the pending write.
    rsv_valid = 1'b1; rsv_addr = 2'd3;
    tick();
    rsv_valid = 1'b0;
    set_req(1, 2'd1, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    req_valid = 3'b010;
    push_grant(1);
    tick();
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_wf", 32'(wf), 32'd0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_w1", 32'(w1), 32'd0);
    check("arst_mask", mask, 32'd0);
    check("arst_w", w, 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("arst_reg1", regf[1], 32'hCAFE_BABE);

    // After reset requester 0 has priority again.
    set_req(0, 2'd1, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
    req_valid = 3'b011;
    push_grant(0);
    push_wr(2'd1, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
    tick();
    req_valid = '0;
    tick(); tick();
    check("post_rst_reg1", regf[1], 32'h0F0F_0F0F);

    check("grants_left", 32'(exp_grant_q.size()), 32'd0);
    check("writes_left", 32'(exp_wr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regwrite_arbiter.md
# regwrite_arbiter

Shares the single write port of the 4-entry `registers` file between several writeback requesters (ALU, load unit, CSR path) using round-robin arbitration. It also keeps a per-register busy scoreboard so the issue stage can stall on outstanding writes. It sits between the writeback sources and the `w1`/`mask`/`wf`/`w` inputs of `registers`, and drives one registered write per cycle.

## Interface

Parameters:
- `N`, 32, data and mask width
- `NREG`, 4, register count; `AW = $clog2(NREG)` = 2
- `NREQ`, 3, number of write requesters

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `req_valid`  in  NREQ  requester i has a write pending
- `req_ready`  out  NREQ  requester i granted this cycle
- `req_addr`  in  NREQ*AW  flattened target addresses; slice i = `[i*AW +: AW]`
- `req_mask`  in  NREQ*N  flattened per-bit write masks
- `req_data`  in  NREQ*N  flattened write data
- `w1`  out  AW  register-file write address
- `mask`  out  N  register-file write mask
- `wf`  out  1  register-file write enable
- `w`  out  N  register-file write data
- `rsv_valid`  in  1  issue stage reserves a destination register
- `rsv_addr`  in  AW  register being reserved
- `r1`, `r2`  in  AW each  issue-stage source addresses
- `busy`  out  NREG  scoreboard bits
- `stall`  out  1  `busy[r1] | busy[r2]`, combinational

## Operation

- **Arbitration.** Round-robin over `req_valid`. Pointer `last` holds the index of the most recent grant. The search starts at `last+1` and wraps modulo NREQ.
  - At most one `req_ready` is high per cycle.
  - `req_ready[i]` is combinational from `req_valid` and `last`, and is never high unless `req_valid[i]` is high.
  - There is no downstream backpressure: a request is accepted whenever it is selected.
- **Pointer update.** `last` advances to the granted index on an accept edge. It holds when no request is valid.
- **Output stage.** On an accept edge, `w1`/`mask`/`w` load the winner's fields. `wf` loads 1 unless the address is 0 or the mask is all-zero, in which case `wf` loads 0. The request still counts as consumed either way. With no accept, `wf` loads 0 and `w1`/`mask`/`w` hold their values.
- **Scoreboard set.** `rsv_valid` with `rsv_addr != 0` sets `busy[rsv_addr]` at the edge. `busy[0]` is constant 0.
- **Scoreboard clear.** An accept edge clears `busy[addr]` of the winner. This applies whether or not `wf` is issued.
- **Simultaneous set and clear.** Same address: the set wins and the bit stays 1. Different addresses: both take effect.
- **Stall.** `stall` reflects current `busy`. There is no bypass: a register whose write is in the output stage is already not busy.
- **Reset.** `rst_n` low forces, asynchronously:
  - `wf=0`, `w1=0`, `mask=0`, `w=0`
  - `busy=0`
  - `last=NREQ-1`, so requester 0 has highest priority first
- **Reset mid-operation.** A pending write in the output stage is dropped, and no `wf` pulse occurs after reset release.

## Timing

- **Write latency.** A request accepted at edge t drives `wf`/`w1`/`mask`/`w` during cycle t..t+1. `registers` commits the write at edge t+1.
- **Throughput.** One write per cycle sustained. A requester holding `valid` continuously gets at most one grant per NREQ cycles while the others are also requesting.
- **Ready timing.**
  - `req_ready` may change in the same cycle `req_valid` rises.
  - Requesters hold their fields stable while `valid` is high and `ready` is low.
  - After an accept, a requester may present a new request in the next cycle.
- **Scoreboard timing.**
  - `busy` changes only at clock edges.
  - `stall` follows `r1`/`r2` combinationally within the cycle.
- **Asynchronous reset.** Assertion takes effect with no clock. Release is synchronized upstream; the block needs no internal synchronizer.

## Structure

- Shared package `regs_pkg`: `N`, `NREG`, `AW`, `REG_ZERO` (= 0), and the `reg_addr_t` typedef. The `registers` module uses the same package.
- Sub-module `rr_arbiter`, parameterized by NREQ. Inputs: `clk`, `rst_n`, `valid`, `accept_en`. Outputs: one-hot `grant`. It owns the `last` pointer.
- Top-level `regwrite_arbiter` holds:
  - the field mux
  - the registered output stage
  - the scoreboard

## Test plan

- **Reset.** Assert `rst_n=0` mid-cycle with a pending write → `wf=0` and `busy=0` immediately. After release, no write occurs.
- **Single requester.** Req1 `addr=1`, `mask=ffffffff`, `data=CAFEBABE` → `req_ready[1]` in the same cycle. Next cycle: `wf=1`, `w1=1`, `w=CAFEBABE`. `registers` then reads `v1=CAFEBABE` at `r1=1`.
- **Round-robin fairness.** All three requesters valid for 6 cycles → grants 0,1,2,0,1,2. Drop req1 → grants alternate 2,0.
- **Suppressed writes.** `addr=0` with data `BABEC0FF` → accepted and `wf=0`; register 0 still reads 0. `addr=2` with `mask=00000000` → accepted and `wf=0`; `busy[2]` clears.
- **Scoreboard.**
  - `rsv_addr=3` → `busy=1000`, and `stall=1` with `r2=3`.
  - A write to 3 accepted with `rsv_addr=3` asserted on the same edge → `busy[3]` stays 1.
  - The next accept to 3 → `busy[3]=0` and `stall=0`.
- **Masked merge.** Two writes to `addr=2`:
  - data `C0FFEEff`, `mask=0000ffff`
  - data `C0FFEEff`, `mask=ffff0000`
  
  → two `wf` pulses, and `registers` reads `C0FFEEff`.
